// File: rtl/mem_defines.sv
// Shared memory-subsystem definitions: AXI encodings and the line-master state enum.
package mem_defines;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Modifiable, bufferable.
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } line_state_e;

endpackage

// File: rtl/axi_line_master.sv
// AXI4 master moving one cache line per request as a single INCR burst,
// one transaction outstanding, result returned on a valid/ready response channel.
module axi_line_master
   import mem_defines::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned AXI_ID     = 0,
   localparam int unsigned LINE_WIDTH = BURST_LEN * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LINE_WIDTH-1:0] req_wdata,

   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [LINE_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,

   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,

   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,

   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,

   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,

   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned SIZE_LOG2 = $clog2(STRB_WIDTH);
   localparam int unsigned OFFS_W    = $clog2(BURST_LEN * STRB_WIDTH);
   localparam int unsigned BEAT_W    = $clog2(BURST_LEN) + 1;
   localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((ADDR_WIDTH'(1) << OFFS_W) - ADDR_WIDTH'(1));

   line_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wline_q, wline_d;
   logic [LINE_WIDTH-1:0] rline_q, rline_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  err_q, err_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  wlast_q, wlast_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;

   // Response IDs carry nothing for a single-outstanding master.
   logic unused_ids;
   assign unused_ids = ^{m_axi_bid, m_axi_rid};

   assign req_ready = (state_q == IDLE) && rst_n;

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wline_d      = wline_q;
      rline_d      = rline_q;
      beat_d       = beat_q;
      err_d        = err_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      wlast_d      = wlast_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr & ALIGN_MASK;
               beat_d    = '0;
               err_d     = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (req_we) begin
                  state_d   = WRITE;
                  wline_d   = req_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  wlast_d   = (LAST_BEAT == '0);
               end else begin
                  state_d   = RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end

         // AW and W run independently; the line buffer shifts one word per beat.
         WRITE: begin
            if (awvalid_q && m_axi_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && m_axi_wready) begin
               if (wlast_q) begin
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  w_done_d = 1'b1;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  wline_d = wline_q >> DATA_WIDTH;
                  wlast_d = (beat_d == LAST_BEAT);
               end
            end
            if (aw_done_d && w_done_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end

         WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d     = 1'b0;
               err_d        = err_q | (m_axi_bresp != AXI_RESP_OKAY);
               resp_err_d   = err_d;
               resp_valid_d = 1'b1;
               state_d      = DONE;
            end
         end

         RD_ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         // Beat count, not rlast, decides when the burst is over.
         RD_DATA: begin
            if (rready_q && m_axi_rvalid) begin
               rline_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
               err_d = err_q | (m_axi_rresp != AXI_RESP_OKAY)
                             | (m_axi_rlast != (beat_q == LAST_BEAT));
               if (beat_q == LAST_BEAT) begin
                  rready_d     = 1'b0;
                  resp_err_d   = err_d;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end

         DONE: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wline_q      <= '0;
         rline_q      <= '0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         wlast_q      <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wline_q      <= wline_d;
         rline_q      <= rline_d;
         beat_q       <= beat_d;
         err_q        <= err_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         wlast_q      <= wlast_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign m_axi_awid    = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'(BURST_LEN - 1);
   assign m_axi_awsize  = 3'(SIZE_LOG2);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = AXI_CACHE_DEFAULT;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;

   assign m_axi_wdata   = wline_q[DATA_WIDTH-1:0];
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = wlast_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

   assign m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = 3'(SIZE_LOG2);
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = AXI_CACHE_DEFAULT;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

   assign resp_valid    = resp_valid_q;
   assign resp_err      = resp_err_q;
   assign resp_rdata    = rline_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: behavioural AXI RAM slave with stall/error injection,
// a line-level reference memory, and a response scoreboard.
module tb_axi_line_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = 8;
   localparam int unsigned BL = 4;
   localparam int unsigned LW = BL * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_wdata;
   logic          resp_valid, resp_ready, resp_err;
   logic [LW-1:0] resp_rdata;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize, awprot, arprot;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awlock, arlock;
   logic [3:0]    awcache, arcache;
   logic          awvalid, awready, wvalid, wready, wlast;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic          bvalid, bready, arvalid, arready, rvalid, rready, rlast;

   always #5 clk = ~clk;

   axi_line_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN(BL), .AXI_ID(0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
      .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
      .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [LW-1:0] rdata;
      logic          err;
      logic          is_read;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] ref_mem [int unsigned];
   logic [DW-1:0] smem    [int unsigned];
   logic [LW-1:0] exp_last_rline = '0;

   logic [AW-1:0] cur_addr  = '0;
   logic [LW-1:0] cur_wline = '0;
   bit            stall_en  = 1'b0;
   bit            inj_bresp = 1'b0;
   int            inj_rresp_beat = -1;
   int            inj_rlast = 0;    // 0 normal, 1 extra rlast on beat 1, 2 no rlast at all

   bit            aw_got, b_pend, r_act;
   int            w_cnt, r_cnt;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wbuf [BL];
   bit            hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp;
   logic          p_awv, p_awr, p_wv, p_wr, p_wl, p_arv, p_arr, p_rspv, p_rspr, p_rerr;
   logic [AW-1:0] p_awaddr, p_araddr;
   logic [DW-1:0] p_wdata;
   logic [LW-1:0] p_rdata;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] model_line(input logic [AW-1:0] a);
      logic [LW-1:0] l;
      int unsigned   wi;
      l = '0;
      for (int k = 0; k < BL; k++) begin
         wi = 32'(a >> 2) + 32'(k);
         l[k*DW +: DW] = ref_mem.exists(wi) ? ref_mem[wi] : '0;
      end
      return l;
   endfunction

   function automatic logic pick(input bit en);
      return en ? 1'($urandom % 2) : 1'b1;
   endfunction

   // AXI RAM slave, protocol monitor and response scoreboard, all at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            aw_got = 0; b_pend = 0; r_act = 0; w_cnt = 0; r_cnt = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_rsp = 0;
            {p_awv, p_awr, p_wv, p_wr, p_wl, p_arv, p_arr, p_rspv, p_rspr, p_rerr} = '0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; resp_ready = 0;
            bresp = 0; rresp = 0; rlast = 0; rdata = 0; bid = 0; rid = 0;
            continue;
         end
         if (hs_aw) aw_got = 1;
         if (hs_w) w_cnt++;
         if (hs_b) begin b_pend = 0; aw_got = 0; w_cnt = 0; bvalid = 0; end
         if (hs_ar) begin r_act = 1; r_cnt = 0; end
         if (hs_r) begin rvalid = 0; r_cnt++; if (r_cnt == BL) r_act = 0; end

         if (p_awv && !p_awr) chk("aw_hold", LW'({awvalid, awaddr}), LW'({1'b1, p_awaddr}));
         if (p_wv && !p_wr) chk("w_hold", LW'({wvalid, wlast, wdata}), LW'({1'b1, p_wl, p_wdata}));
         if (p_arv && !p_arr) chk("ar_hold", LW'({arvalid, araddr}), LW'({1'b1, p_araddr}));
         if (p_rspv && !p_rspr) begin
            chk("resp_hold", LW'({resp_valid, resp_err}), LW'({1'b1, p_rerr}));
            chk("resp_rdata_hold", resp_rdata, p_rdata);
         end

         awready    = pick(stall_en);
         wready     = pick(stall_en);
         arready    = pick(stall_en);
         resp_ready = pick(stall_en);
         if (aw_got && w_cnt == BL && !b_pend) begin
            for (int k = 0; k < BL; k++) smem[32'(waddr >> 2) + 32'(k)] = wbuf[k];
            b_pend = 1;
         end
         if (b_pend && !bvalid) begin
            bvalid = pick(stall_en);
            bresp  = inj_bresp ? 2'b10 : 2'b00;
         end
         if (r_act && !rvalid && pick(stall_en)) begin
            rvalid = 1;
            rdata  = smem.exists(32'(raddr >> 2) + 32'(r_cnt)) ?
                     smem[32'(raddr >> 2) + 32'(r_cnt)] : '0;
            rresp  = (r_cnt == inj_rresp_beat) ? 2'b11 : 2'b00;
            rlast  = (inj_rlast == 2) ? 1'b0 :
                     ((r_cnt == BL - 1) || (inj_rlast == 1 && r_cnt == 1));
         end

         hs_aw  = awvalid && awready;
         hs_w   = wvalid && wready;
         hs_b   = bvalid && bready;
         hs_ar  = arvalid && arready;
         hs_r   = rvalid && rready;
         hs_rsp = resp_valid && resp_ready;

         if (hs_aw) begin
            chk("awaddr", LW'(awaddr), LW'(cur_addr));
            chk("aw_ctl", LW'({awid, awlen, awsize, awburst, awlock, awcache, awprot}),
                LW'({8'd0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
            waddr = awaddr;
         end
         if (hs_w) begin
            chk("wlast", LW'(wlast), LW'(w_cnt == BL - 1));
            chk("wdata", LW'(wdata), LW'(cur_wline[w_cnt*DW +: DW]));
            chk("wstrb", LW'(wstrb), LW'(4'hF));
            if (w_cnt < BL) wbuf[w_cnt] = wdata;
         end
         if (hs_ar) begin
            chk("araddr", LW'(araddr), LW'(cur_addr));
            chk("ar_ctl", LW'({arid, arlen, arsize, arburst, arlock, arcache, arprot}),
                LW'({8'd0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
            raddr = araddr;
         end
         if (hs_rsp) begin
            if (sb_q.size() == 0) begin
               chk("resp_unexpected", LW'(sb_q.size()), LW'(1));
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", LW'(resp_err), LW'(e.err));
               if (e.is_read) chk("rd_beats", LW'(r_cnt), LW'(BL));
            end
         end

         p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
         p_wv = wvalid; p_wr = wready; p_wl = wlast; p_wdata = wdata;
         p_arv = arvalid; p_arr = arready; p_araddr = araddr;
         p_rspv = resp_valid; p_rspr = resp_ready; p_rerr = resp_err; p_rdata = resp_rdata;
      end
   end

   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] line);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk); #2;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = line;
      while (!req_ready && n < 200) begin
         @(negedge clk); #2;
         n++;
      end
      if (!req_ready) begin
         chk("req_accept", LW'(req_ready), LW'(1));
         req_valid = 1'b0;
         return;
      end
      cur_addr  = addr & ~AW'(BL * SW - 1);
      cur_wline = line;
      if (we) begin
         for (int k = 0; k < BL; k++) ref_mem[32'(cur_addr >> 2) + 32'(k)] = line[k*DW +: DW];
         e.rdata   = exp_last_rline;
         e.err     = inj_bresp;
         e.is_read = 1'b0;
      end else begin
         e.rdata        = model_line(cur_addr);
         exp_last_rline = e.rdata;
         e.err          = (inj_rresp_beat >= 0) || (inj_rlast != 0);
         e.is_read      = 1'b1;
      end
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("txn_complete", LW'(sb_q.size()), LW'(0));
      sb_q.delete();
      @(negedge clk);
   endtask

   task automatic run(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] line);
      do_req(we, addr, line);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [LW-1:0] rnd_line;
   logic [AW-1:0] rnd_addr;
   logic          rnd_we;
   int            n;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctl", LW'({awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err, req_ready}), '0);
      chk("reset_rdata", resp_rdata, '0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("req_ready_idle", LW'(req_ready), LW'(1));

      // Write then read back, no stalls.
      run(1'b1, 32'h100, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      run(1'b0, 32'h100, '0);
      // Unaligned request address.
      run(1'b0, 32'h10C, '0);

      stall_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rnd_we   = 1'($urandom % 2);
         rnd_addr = AW'(32'h1000 + ($urandom % 8) * 16 + ($urandom % 16));
         rnd_line = {$urandom, $urandom, $urandom, $urandom};
         run(rnd_we, rnd_addr, rnd_line);
      end

      inj_bresp = 1'b1;
      run(1'b1, 32'h3000, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      inj_bresp = 1'b0;
      inj_rresp_beat = 2;
      run(1'b0, 32'h3000, '0);
      inj_rresp_beat = -1;
      inj_rlast = 1;
      run(1'b0, 32'h3004, '0);
      inj_rlast = 2;
      run(1'b0, 32'h3008, '0);
      inj_rlast = 0;
      run(1'b0, 32'h3000, '0);

      // Reset in the middle of a write burst.
      do_req(1'b1, 32'h2000, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
      n = 0;
      while (w_cnt < 2 && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      chk("w_beat1_reached", LW'(w_cnt >= 2), LW'(1));
      rst_n = 1'b0;
      #1;
      chk("async_reset_ctl", LW'({awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready}), '0);
      sb_q.delete();
      exp_last_rline = '0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("req_ready_after_reset", LW'(req_ready), LW'(1));
      run(1'b1, 32'h2000, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
      run(1'b0, 32'h2000, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
